// File: rtl/mux_4x1_2bit_arbiter.sv
// Round-robin arbiter for four requesters. The grant drives the select lines
// of the gate-level 2-bit 4x1 mux, and the selected word is registered with a valid flag.

module mux_4x1_2bit (
  input  logic A1,
  input  logic A0,
  input  logic B1,
  input  logic B0,
  input  logic C1,
  input  logic C0,
  input  logic D1,
  input  logic D0,
  input  logic S1,
  input  logic S0,
  output logic Y1,
  output logic Y0
);
  logic ns1;
  logic ns0;
  logic sel_a;
  logic sel_b;
  logic sel_c;
  logic sel_d;

  assign ns1   = ~S1;
  assign ns0   = ~S0;
  assign sel_a = ns1 & ns0;
  assign sel_b = ns1 & S0;
  assign sel_c = S1 & ns0;
  assign sel_d = S1 & S0;

  assign Y1 = (A1 & sel_a) | (B1 & sel_b) | (C1 & sel_c) | (D1 & sel_d);
  assign Y0 = (A0 & sel_a) | (B0 & sel_b) | (C0 & sel_c) | (D0 & sel_d);
endmodule

module mux_4x1_2bit_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       Clk_s,
  input  logic       Rst_s,
  input  logic [3:0] Req_s,
  input  logic [1:0] A_s,
  input  logic [1:0] B_s,
  input  logic [1:0] C_s,
  input  logic [1:0] D_s,
  output logic [1:0] S_s,
  output logic [3:0] Gnt_s,
  output logic [1:0] Out_s,
  output logic       Valid_s
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] others;
  logic [2:0] first_pick;
  logic [2:0] next_pick;
  logic [1:0] mux_y;

  // Returns {hit, index}; candidates closer to start (in rotation order) win.
  function automatic logic [2:0] arbitrate(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] cand;
    logic [2:0] result;
    result = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (mask[cand]) begin
        result = {1'b1, cand};
      end
    end
    return result;
  endfunction

  assign others     = Req_s & ~(4'b0001 << idx_q);
  assign first_pick = arbitrate(Req_s, ptr_q);
  assign next_pick  = arbitrate(others, idx_q + 2'd1);

  always_ff @(posedge Clk_s or negedge Rst_s) begin
    if (!Rst_s) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release takes precedence over forced rotation; both hand over with no bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|Req_s) begin
          state_d = GRANT;
          idx_d   = first_pick[1:0];
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (!Req_s[idx_q]) begin
          ptr_d = idx_q + 2'd1;
          if (next_pick[2]) begin
            idx_d = next_pick[1:0];
            cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_q >= HOLD_CNT) && (|others)) begin
          ptr_d = idx_q + 2'd1;
          idx_d = next_pick[1:0];
          cnt_d = 4'd1;
        end else if (cnt_q < HOLD_CNT) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Gnt_s = (state_q == GRANT) ? (4'b0001 << idx_q) : 4'b0000;
  assign S_s   = (state_q == GRANT) ? idx_q : 2'b00;

  mux_4x1_2bit u_mux (
    .A1(A_s[1]), .A0(A_s[0]),
    .B1(B_s[1]), .B0(B_s[0]),
    .C1(C_s[1]), .C0(C_s[0]),
    .D1(D_s[1]), .D0(D_s[0]),
    .S1(S_s[1]), .S0(S_s[0]),
    .Y1(mux_y[1]), .Y0(mux_y[0])
  );

  always_ff @(posedge Clk_s or negedge Rst_s) begin
    if (!Rst_s) begin
      Out_s   <= 2'b00;
      Valid_s <= 1'b0;
    end else if (|Gnt_s) begin
      Out_s   <= mux_y;
      Valid_s <= 1'b1;
    end else begin
      Valid_s <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_4x1_2bit_arbiter.sv
// Scoreboard bench for the round-robin mux arbiter: a cycle model predicts
// outputs per step, and directed checks cover the test-plan scenarios.

module tb_mux_4x1_2bit_arbiter;
  localparam int HOLD = 4;

  logic       Clk_s;
  logic       Rst_s;
  logic [3:0] Req_s;
  logic [1:0] A_s;
  logic [1:0] B_s;
  logic [1:0] C_s;
  logic [1:0] D_s;
  logic [1:0] S_s;
  logic [3:0] Gnt_s;
  logic [1:0] Out_s;
  logic       Valid_s;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] s;
    logic [1:0] out;
    logic       valid;
  } exp_t;

  exp_t sb[$];

  int checks;
  int failures;

  bit         m_grant;
  logic [1:0] m_idx;
  logic [1:0] m_ptr;
  int         m_cnt;
  logic [1:0] m_out;
  bit         m_valid;

  mux_4x1_2bit_arbiter #(.HOLD_MAX(HOLD)) dut (
    .Clk_s  (Clk_s),
    .Rst_s  (Rst_s),
    .Req_s  (Req_s),
    .A_s    (A_s),
    .B_s    (B_s),
    .C_s    (C_s),
    .D_s    (D_s),
    .S_s    (S_s),
    .Gnt_s  (Gnt_s),
    .Out_s  (Out_s),
    .Valid_s(Valid_s)
  );

  initial Clk_s = 1'b0;
  always #5 Clk_s = ~Clk_s;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] mask, input logic [1:0] start);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (int'(start) + k) % 4;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_grant = 0;
    m_idx   = 2'd0;
    m_ptr   = 2'd0;
    m_cnt   = 0;
    m_out   = 2'd0;
    m_valid = 0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
  task automatic step(input logic [3:0] req, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d);
    logic [1:0] data [4];
    logic [3:0] rest;
    int         w;
    exp_t       e;
    exp_t       got;
    Req_s = req; A_s = a; B_s = b; C_s = c; D_s = d;
    data[0] = a; data[1] = b; data[2] = c; data[3] = d;
    if (m_grant) begin
      m_out   = data[m_idx];
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    rest = req & ~(4'b0001 << m_idx);
    if (!m_grant) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_grant = 1;
        m_idx   = 2'(w);
        m_cnt   = 1;
      end
    end else if (!req[m_idx]) begin
      m_ptr = m_idx + 2'd1;
      w = pick(rest, m_ptr);
      if (w >= 0) begin
        m_idx = 2'(w);
        m_cnt = 1;
      end else begin
        m_grant = 0;
      end
    end else if (m_cnt == HOLD && rest != 4'b0000) begin
      m_ptr = m_idx + 2'd1;
      m_idx = 2'(pick(rest, m_ptr));
      m_cnt = 1;
    end else if (m_cnt < HOLD) begin
      m_cnt++;
    end
    e.gnt   = m_grant ? (4'b0001 << m_idx) : 4'b0000;
    e.s     = m_grant ? m_idx : 2'b00;
    e.out   = m_out;
    e.valid = m_valid;
    sb.push_back(e);
    @(posedge Clk_s);
    #1;
    got = sb.pop_front();
    chk("sb_gnt", {4'b0, Gnt_s}, {4'b0, got.gnt});
    chk("sb_sel", {6'b0, S_s}, {6'b0, got.s});
    chk("sb_out", {6'b0, Out_s}, {6'b0, got.out});
    chk("sb_valid", {7'b0, Valid_s}, {7'b0, got.valid});
  endtask

  task automatic pulse_reset();
    #2;
    Rst_s = 1'b0;
    #1;
    model_reset();
    #1;
    Rst_s = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst_s = 1'b0;
    Req_s = 4'b0000;
    A_s = 2'b00; B_s = 2'b00; C_s = 2'b00; D_s = 2'b00;
    model_reset();
    #3;
    chk("reset_gnt", {4'b0, Gnt_s}, 8'h00);
    chk("reset_sel", {6'b0, S_s}, 8'h00);
    chk("reset_out", {6'b0, Out_s}, 8'h00);
    chk("reset_valid", {7'b0, Valid_s}, 8'h00);
    Rst_s = 1'b1;

    // Single requester C holds the grant indefinitely.
    step(4'b0100, 2'b01, 2'b11, 2'b10, 2'b00);
    chk("single_gnt", {4'b0, Gnt_s}, 8'h04);
    chk("single_sel", {6'b0, S_s}, 8'h02);
    step(4'b0100, 2'b01, 2'b11, 2'b10, 2'b00);
    chk("single_out", {6'b0, Out_s}, 8'h02);
    chk("single_valid", {7'b0, Valid_s}, 8'h01);
    for (int i = 0; i < 6; i++) step(4'b0100, 2'b01, 2'b11, 2'b10, 2'b00);
    chk("single_persist", {4'b0, Gnt_s}, 8'h04);

    // Asynchronous reset in the middle of a grant.
    step(4'b0101, 2'b01, 2'b11, 2'b10, 2'b00);
    #2;
    Rst_s = 1'b0;
    #1;
    chk("midreset_gnt", {4'b0, Gnt_s}, 8'h00);
    chk("midreset_sel", {6'b0, S_s}, 8'h00);
    chk("midreset_out", {6'b0, Out_s}, 8'h00);
    chk("midreset_valid", {7'b0, Valid_s}, 8'h00);
    model_reset();
    #1;
    Rst_s = 1'b1;
    step(4'b0101, 2'b01, 2'b11, 2'b10, 2'b00);
    chk("postreset_gnt", {4'b0, Gnt_s}, 8'h01);

    // Full contention rotates every HOLD cycles and wraps back to A.
    pulse_reset();
    for (int i = 0; i <= 4 * HOLD; i++) begin
      step(4'b1111, 2'b00, 2'b01, 2'b10, 2'b11);
      chk($sformatf("rr_gnt_%0d", i), {4'b0, Gnt_s}, {4'b0, 4'b0001 << ((i / HOLD) % 4)});
    end

    // A releases early; B takes over with no gap.
    pulse_reset();
    step(4'b0011, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("early_gnt0", {4'b0, Gnt_s}, 8'h01);
    step(4'b0011, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("early_gnt1", {4'b0, Gnt_s}, 8'h01);
    step(4'b0010, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("early_gnt2", {4'b0, Gnt_s}, 8'h02);
    chk("early_valid", {7'b0, Valid_s}, 8'h01);

    // B releases with A, C, D pending: pointer moves past B, so C wins.
    step(4'b1101, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("fair_gnt", {4'b0, Gnt_s}, 8'h04);

    // C releases to B, then B, the only requester, drops to idle.
    step(4'b0010, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("idle_prep_gnt", {4'b0, Gnt_s}, 8'h02);
    step(4'b0000, 2'b10, 2'b01, 2'b11, 2'b00);
    chk("idle_gnt", {4'b0, Gnt_s}, 8'h00);
    chk("idle_sel", {6'b0, S_s}, 8'h00);
    chk("idle_valid_lag", {7'b0, Valid_s}, 8'h01);
    step(4'b0000, 2'b10, 2'b00, 2'b11, 2'b00);
    chk("idle_valid", {7'b0, Valid_s}, 8'h00);
    chk("idle_out_hold", {6'b0, Out_s}, 8'h01);

    // Random traffic against the model.
    for (int i = 0; i < 120; i++) begin
      step(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_4x1_2bit_arbiter.md
# mux_4x1_2bit_arbiter

Round-robin arbiter and sequencer for the 2-bit 4x1 gate-level mux. Four requesters (A, B, C, D) compete for the mux. The block grants one requester at a time and drives the mux select lines from the grant. It also registers the selected 2-bit word with a valid flag for the downstream consumer. It instantiates the existing 2-bit 4x1 gate mux as its datapath; this block owns the select and adds no datapath logic of its own.

## Interface
- HOLD_MAX, default 4: maximum consecutive grant cycles for one requester while another requester is pending; legal range 1..15.
- Clk_s  input  1  clock; all state updates on the rising edge.
- Rst_s  input  1  reset; asynchronous, active-low. Asserted (0) clears all state immediately.
- Req_s  input  4  request vector; bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive.
- A_s, B_s, C_s, D_s  input  2 each  requester data words; feed mux inputs {A1,A0} .. {D1,D0}.
- S_s  output  2  mux select {S1,S0}; equals the index of the granted requester; 0 when idle.
- Gnt_s  output  4  one-hot grant, registered; all zero when idle.
- Out_s  output  2  registered mux output; holds its last value when not valid.
- Valid_s  output  1  Out_s carries data from a granted requester.

## Operation
- **State:** FSM {IDLE, GRANT}; 2-bit grant index Idx; 2-bit round-robin pointer Ptr; 4-bit hold counter Cnt.
- **Arbitration function:** takes a candidate mask and searches Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4). The first set bit wins.
- **IDLE:**
  - If Req_s is nonzero, arbitrate over Req_s, load Idx, set Cnt=1 and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT,** evaluated each cycle in this priority order:
  1. **Release:** Req_s[Idx]=0. Set Ptr=Idx+1 and arbitrate over Req_s with bit Idx masked.
     - On a hit, load the new Idx with Cnt=1 and stay in GRANT; there is no bubble cycle.
     - With no hit, go to IDLE.
  2. **Forced rotation:** Cnt==HOLD_MAX and another Req_s bit is set. Set Ptr=Idx+1, arbitrate with Idx masked, and load the new Idx with Cnt=1.
  3. **Hold:** otherwise keep Idx and set Cnt=Cnt+1. Cnt saturates at HOLD_MAX; it does not wrap.
- **Derived outputs:**
  - Gnt_s = one-hot(Idx) in GRANT, 0 in IDLE.
  - S_s = Idx in GRANT, 2'b00 in IDLE.
- **Datapath:**
  - The mux output is sampled every cycle.
  - When Gnt_s is nonzero, Out_s is loaded with the mux output and Valid_s is set to 1.
  - Otherwise Valid_s is set to 0 and Out_s holds.
- **Ptr wrap:** Ptr wraps 3→0, so D releasing makes A the highest-priority candidate.
- **Simultaneous events:** if release and HOLD_MAX are reached in the same cycle, release applies; the result is identical either way.
- **Request deassert:** a requester that drops its request on the cycle its grant would start is still granted that one cycle. Req_s is sampled in the previous cycle; the granted requester must tolerate this.
- **Reset mid-operation:** all outputs clear asynchronously on reset assertion. After Rst_s returns to 1, arbitration restarts from Ptr=0 on the next edge.

## Timing
- **Reset values:** S_s=00, Gnt_s=0000, Out_s=00, Valid_s=0; FSM=IDLE, Ptr=0, Cnt=0.
- **Request to grant:** request seen at edge N → Gnt_s and S_s valid after edge N+1. Latency is 1 cycle from IDLE.
- **Grant to data:** Gnt_s active in cycle k → Out_s and Valid_s reflect that requester's data after the next edge. Latency is 1 cycle.
- **Handover:** back-to-back handover between requesters has zero idle cycles on Gnt_s. Valid_s stays high continuously.
- **Maximum tenure:** HOLD_MAX consecutive Gnt_s cycles per requester while others wait.
- **Worst-case wait:** 3×HOLD_MAX cycles plus 1 cycle from request to grant.

## Test plan
- **Reset:** assert Rst_s=0 mid-GRANT with Req_s=0101 → S_s=00, Gnt_s=0000, Valid_s=0, Out_s=00 immediately. After release with Req_s=0101, first Gnt_s=0001.
- **Single requester:** Req_s=0100, C_s=2'b10 held → Gnt_s=0100 and S_s=10 one cycle later; Out_s=10 with Valid_s=1 the cycle after. Grant persists indefinitely; Cnt saturates.
- **Round-robin with HOLD_MAX=4:** Req_s=1111 held, all data distinct → Gnt_s sequence is 0001×4, 0010×4, 0100×4, 1000×4, then 0001 again (wrap). No gap cycles.
- **Early release:** Req_s=0011; A drops after 2 grant cycles → Gnt_s 0001, 0001, then 0010 on the next cycle.
- **Release to idle:** the only requester, B, drops → Gnt_s=0000 and S_s=00 next cycle. Valid_s falls one cycle later; Out_s holds B's last word.
- **Pointer fairness:** B granted and released with Req_s=1101 pending → next grant goes to C (0100), not A.
